// File: rtl/jtag_pkg.sv
// Shared types and constants for the DTM JTAG TAP: TAP state encoding,
// instruction opcodes and the DTMCS register layout.
package jtag_pkg;

  typedef enum logic [3:0] {
    TestLogicReset,
    RunTestIdle,
    SelectDrScan,
    CaptureDr,
    ShiftDr,
    Exit1Dr,
    PauseDr,
    Exit2Dr,
    UpdateDr,
    SelectIrScan,
    CaptureIr,
    ShiftIr,
    Exit1Ir,
    PauseIr,
    Exit2Ir,
    UpdateIr
  } tap_state_e;

  // 5-bit opcodes; anything not listed falls back to BYPASS
  localparam logic [4:0] IR_BYPASS0   = 5'h00;
  localparam logic [4:0] IR_IDCODE    = 5'h01;
  localparam logic [4:0] IR_DTMCSR    = 5'h10;
  localparam logic [4:0] IR_DMIACCESS = 5'h11;
  localparam logic [4:0] IR_BYPASS1   = 5'h1F;

  // Fixed pattern loaded into the IR shifter on CaptureIr (LSBs = 2'b01)
  localparam logic [4:0] IR_CAPTURE   = 5'b00101;

  localparam logic [3:0] DTM_VERSION  = 4'd1;
  localparam logic [5:0] DMI_ABITS    = 6'd7;
  localparam logic [2:0] DTM_IDLE     = 3'd1;

  // Bit positions of the write-only strobes inside a shifted DTMCS word
  localparam int unsigned DTMCS_DMIRESET_BIT  = 16;
  localparam int unsigned DTMCS_HARDRESET_BIT = 17;

  typedef struct packed {
    logic [13:0] zero1;
    logic        dmihardreset;
    logic        dmireset;
    logic        zero0;
    logic [2:0]  idle;
    logic [1:0]  dmistat;
    logic [5:0]  abits;
    logic [3:0]  version;
  } dtmcs_t;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 16-state TAP state machine: state register plus next-state
// decode from TMS. Asynchronous active-low reset lands in TestLogicReset.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck_i,
  input  logic       trst_ni,
  input  logic       tms_i,
  output tap_state_e state_o
);

  tap_state_e state_q, state_d;

  // State register
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) state_q <= TestLogicReset;
    else          state_q <= state_d;
  end

  // Standard TAP transitions; five TMS=1 cycles reach TestLogicReset
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TestLogicReset: state_d = tms_i ? TestLogicReset : RunTestIdle;
      RunTestIdle:    state_d = tms_i ? SelectDrScan   : RunTestIdle;
      SelectDrScan:   state_d = tms_i ? SelectIrScan   : CaptureDr;
      CaptureDr:      state_d = tms_i ? Exit1Dr        : ShiftDr;
      ShiftDr:        state_d = tms_i ? Exit1Dr        : ShiftDr;
      Exit1Dr:        state_d = tms_i ? UpdateDr       : PauseDr;
      PauseDr:        state_d = tms_i ? Exit2Dr        : PauseDr;
      Exit2Dr:        state_d = tms_i ? UpdateDr       : ShiftDr;
      UpdateDr:       state_d = tms_i ? SelectDrScan   : RunTestIdle;
      SelectIrScan:   state_d = tms_i ? TestLogicReset : CaptureIr;
      CaptureIr:      state_d = tms_i ? Exit1Ir        : ShiftIr;
      ShiftIr:        state_d = tms_i ? Exit1Ir        : ShiftIr;
      Exit1Ir:        state_d = tms_i ? UpdateIr       : PauseIr;
      PauseIr:        state_d = tms_i ? Exit2Ir        : PauseIr;
      Exit2Ir:        state_d = tms_i ? UpdateIr       : ShiftIr;
      UpdateIr:       state_d = tms_i ? SelectDrScan   : RunTestIdle;
      default:        state_d = TestLogicReset;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// DTM JTAG TAP controller: instruction register, IDCODE/BYPASS/DTMCS data
// registers, strobes for the downstream DMI stage and the negedge TDO stage.
// Optional build macro JTAG_TAP_HARDRESET_EN enables dtmcs.dmihardreset.
module jtag_tap_ctrl
  import jtag_pkg::*;
#(
  parameter int unsigned IrLength    = 5,
  parameter logic [31:0] IdcodeValue = 32'h00000001
) (
  input  logic       tck_i,
  input  logic       trst_ni,
  input  logic       tms_i,
  input  logic       td_i,
  output logic       td_o,
  output logic       tdo_oe_o,
  input  logic       testmode_i,
  output logic       test_logic_reset_o,
  output logic       shift_dr_o,
  output logic       update_dr_o,
  output logic       capture_dr_o,
  output logic       dmi_access_o,
  output logic       dtmcs_select_o,
  output logic       dmi_reset_o,
  input  logic [1:0] dmi_error_i,
  output logic       dmi_tdi_o,
  input  logic       dmi_tdo_i,
  output logic       dmi_hardreset_o
);

  localparam logic [IrLength-1:0] IrIdcode  = IrLength'(IR_IDCODE);
  localparam logic [IrLength-1:0] IrDtmcs   = IrLength'(IR_DTMCSR);
  localparam logic [IrLength-1:0] IrDmi     = IrLength'(IR_DMIACCESS);
  localparam logic [IrLength-1:0] IrCapture = IrLength'(IR_CAPTURE);

  tap_state_e state;
  logic       capture_ir, shift_ir, update_ir;

  jtag_tap_fsm u_fsm (
    .tck_i   (tck_i),
    .trst_ni (trst_ni),
    .tms_i   (tms_i),
    .state_o (state)
  );

  // Strobes are plain decodes of the current TAP state
  always_comb begin
    test_logic_reset_o = (state == TestLogicReset);
    capture_dr_o       = (state == CaptureDr);
    shift_dr_o         = (state == ShiftDr);
    update_dr_o        = (state == UpdateDr);
    capture_ir         = (state == CaptureIr);
    shift_ir           = (state == ShiftIr);
    update_ir          = (state == UpdateIr);
  end

  // ---------------------------------------------------------------------------
  // Instruction register
  // ---------------------------------------------------------------------------
  logic [IrLength-1:0] ir_q, ir_shift_q;

  // IR shifter captures the fixed pattern, shifts LSB-first; IR loads on update
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      ir_shift_q <= '0;
      ir_q       <= IrIdcode;
    end else begin
      if (capture_ir)    ir_shift_q <= IrCapture;
      else if (shift_ir) ir_shift_q <= {td_i, ir_shift_q[IrLength-1:1]};

      if (test_logic_reset_o) ir_q <= IrIdcode;
      else if (update_ir)     ir_q <= ir_shift_q;
    end
  end

  logic idcode_sel, bypass_sel;

  assign idcode_sel     = (ir_q == IrIdcode);
  assign dtmcs_select_o = (ir_q == IrDtmcs);
  assign dmi_access_o   = (ir_q == IrDmi);
  assign bypass_sel     = !(idcode_sel || dtmcs_select_o || dmi_access_o);

  // ---------------------------------------------------------------------------
  // Data registers
  // ---------------------------------------------------------------------------
  logic [31:0] idcode_q, dtmcs_q;
  logic        bypass_q;
  dtmcs_t      dtmcs_cap;

  // Read view of DTMCS; strobe bits always read back as zero
  always_comb begin
    dtmcs_cap         = '0;
    dtmcs_cap.idle    = DTM_IDLE;
    dtmcs_cap.dmistat = dmi_error_i;
    dtmcs_cap.abits   = DMI_ABITS;
    dtmcs_cap.version = DTM_VERSION;
  end

  // Capture/shift of the locally held DRs; Pause states simply hold
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      idcode_q <= '0;
      dtmcs_q  <= '0;
      bypass_q <= 1'b0;
    end else if (capture_dr_o) begin
      if (idcode_sel)     idcode_q <= IdcodeValue;
      if (dtmcs_select_o) dtmcs_q  <= dtmcs_cap;
      if (bypass_sel)     bypass_q <= 1'b0;
    end else if (shift_dr_o) begin
      if (idcode_sel)     idcode_q <= {td_i, idcode_q[31:1]};
      if (dtmcs_select_o) dtmcs_q  <= {td_i, dtmcs_q[31:1]};
      if (bypass_sel)     bypass_q <= td_i;
    end
  end

  // ---------------------------------------------------------------------------
  // DTMCS write strobes
  // ---------------------------------------------------------------------------
  logic upd_dtmcs, hardreset_d, dmi_reset_d, dmi_reset_q;

  assign upd_dtmcs = update_dr_o & dtmcs_select_o;

`ifdef JTAG_TAP_HARDRESET_EN
  logic dmi_hardreset_q;

  assign hardreset_d = upd_dtmcs & dtmcs_q[DTMCS_HARDRESET_BIT];

  // One-cycle hard-reset pulse following the UpdateDr that requested it
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) dmi_hardreset_q <= 1'b0;
    else          dmi_hardreset_q <= hardreset_d;
  end

  assign dmi_hardreset_o = dmi_hardreset_q;
`else
  assign hardreset_d     = 1'b0;
  assign dmi_hardreset_o = 1'b0;
`endif

  // A hard reset also implies a DMI reset in the same cycle
  assign dmi_reset_d = upd_dtmcs & (dtmcs_q[DTMCS_DMIRESET_BIT] | hardreset_d);

  // One-cycle DMI reset pulse following the UpdateDr that requested it
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) dmi_reset_q <= 1'b0;
    else          dmi_reset_q <= dmi_reset_d;
  end

  assign dmi_reset_o = dmi_reset_q;
  assign dmi_tdi_o   = td_i;

  // ---------------------------------------------------------------------------
  // TDO path
  // ---------------------------------------------------------------------------
  logic tdo_mux;

  // IR shifter LSB during ShiftIr, otherwise the LSB of the selected DR
  always_comb begin
    tdo_mux = bypass_q;
    if (shift_ir)            tdo_mux = ir_shift_q[0];
    else if (dmi_access_o)   tdo_mux = dmi_tdo_i;
    else if (dtmcs_select_o) tdo_mux = dtmcs_q[0];
    else if (idcode_sel)     tdo_mux = idcode_q[0];
  end

  // Falling-edge launch in functional mode; in scan mode the true clock is
  // used so these flops share the scan clock polarity.
  logic tck_tdo, td_q, tdo_oe_q;

  assign tck_tdo = testmode_i ? tck_i : ~tck_i;

  // TDO and its enable change half a cycle after the rising edge
  always_ff @(posedge tck_tdo or negedge trst_ni) begin
    if (!trst_ni) begin
      td_q     <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else begin
      td_q     <= tdo_mux;
      tdo_oe_q <= shift_ir | shift_dr_o;
    end
  end

  assign td_o     = td_q;
  assign tdo_oe_o = tdo_oe_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl: IDCODE, BYPASS, DTMCS, DMI access,
// TMS reset path and asynchronous TRST.
module tb_jtag_tap_ctrl;

  logic       tck_i = 1'b0;
  logic       trst_ni = 1'b0;
  logic       tms_i = 1'b1;
  logic       td_i = 1'b0;
  logic       testmode_i = 1'b0;
  logic [1:0] dmi_error_i = 2'b00;
  logic       dmi_tdo_i;
  logic       td_o, tdo_oe_o, test_logic_reset_o, shift_dr_o, update_dr_o;
  logic       capture_dr_o, dmi_access_o, dtmcs_select_o, dmi_reset_o;
  logic       dmi_tdi_o, dmi_hardreset_o;

  int checks = 0;
  int errors = 0;

  jtag_tap_ctrl dut (
    .tck_i              (tck_i),
    .trst_ni            (trst_ni),
    .tms_i              (tms_i),
    .td_i               (td_i),
    .td_o               (td_o),
    .tdo_oe_o           (tdo_oe_o),
    .testmode_i         (testmode_i),
    .test_logic_reset_o (test_logic_reset_o),
    .shift_dr_o         (shift_dr_o),
    .update_dr_o        (update_dr_o),
    .capture_dr_o       (capture_dr_o),
    .dmi_access_o       (dmi_access_o),
    .dtmcs_select_o     (dtmcs_select_o),
    .dmi_reset_o        (dmi_reset_o),
    .dmi_error_i        (dmi_error_i),
    .dmi_tdi_o          (dmi_tdi_o),
    .dmi_tdo_i          (dmi_tdo_i),
    .dmi_hardreset_o    (dmi_hardreset_o)
  );

  always #5 tck_i = ~tck_i;

  // Stand-in for the downstream DMI register: 41 bits, loads a pattern
  localparam logic [40:0] DMI_PAT = 41'h0AB_CDEF_0123;
  logic [40:0] dmi_sr = '0;
  always @(posedge tck_i) begin
    if (dmi_access_o && capture_dr_o)    dmi_sr <= DMI_PAT;
    else if (dmi_access_o && shift_dr_o) dmi_sr <= {dmi_tdi_o, dmi_sr[40:1]};
  end
  assign dmi_tdo_i = dmi_sr[0];

  // Per-cycle strobe counters sampled mid-cycle
  int n_cap = 0, n_shf = 0, n_upd = 0, n_rst = 0, n_hrst = 0;
  always @(negedge tck_i) begin
    n_cap  <= n_cap  + int'(capture_dr_o);
    n_shf  <= n_shf  + int'(shift_dr_o);
    n_upd  <= n_upd  + int'(update_dr_o);
    n_rst  <= n_rst  + int'(dmi_reset_o);
    n_hrst <= n_hrst + int'(dmi_hardreset_o);
  end

  logic s_cap, s_shf, s_upd, s_rst;
  logic c_cap, c_shf0, c_upd, c_rst_upd, c_rst_idle;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One TCK: drive while low, sample strobes after rise, TDO after fall
  task automatic step(input logic tms, input logic tdi);
    tms_i = tms;
    td_i  = tdi;
    @(posedge tck_i); #1;
    s_cap = capture_dr_o;
    s_shf = shift_dr_o;
    s_upd = update_dr_o;
    s_rst = dmi_reset_o;
    @(negedge tck_i); #1;
  endtask

  task automatic tlr_to_idle();
    repeat (5) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  // From RunTestIdle, shift a 5-bit IR, return to RunTestIdle
  task automatic shift_ir(input logic [4:0] ir, output logic [4:0] cap);
    cap = '0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    cap[0] = td_o;
    for (int i = 0; i < 5; i++) begin
      step(i == 4, ir[i]);
      if (i < 4) cap[i+1] = td_o;
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  // From RunTestIdle, capture and shift n DR bits, update, back to idle
  task automatic shift_dr(input logic [63:0] din, input int n, output logic [63:0] dout);
    dout = '0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    c_cap = s_cap;
    step(1'b0, 1'b0);
    c_shf0 = s_shf;
    dout[0] = td_o;
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, din[i]);
      if (i < n - 1) dout[i+1] = td_o;
    end
    step(1'b1, 1'b0);
    c_upd     = s_upd;
    c_rst_upd = s_rst;
    step(1'b0, 1'b0);
    c_rst_idle = s_rst;
  endtask

  logic [63:0] d;
  logic [4:0]  irc;
  int          r0, h0, a0, b0, u0;
  int          exp_hr;

  initial begin
    // Reset state
    #12;
    chk("rst_tlr", 64'(test_logic_reset_o), 64'd1);
    chk("rst_tdo", 64'({td_o, tdo_oe_o}), 64'd0);
    chk("rst_strobes", 64'({shift_dr_o, update_dr_o, capture_dr_o, dmi_reset_o, dmi_hardreset_o}), 64'd0);
    chk("rst_irdec", 64'({dmi_access_o, dtmcs_select_o}), 64'd0);
    trst_ni = 1'b1;
    @(negedge tck_i); #1;

    // IDCODE after reset
    tlr_to_idle();
    chk("idle_tlr", 64'(test_logic_reset_o), 64'd0);
    shift_dr(64'd0, 32, d);
    chk("idcode", d, 64'h0000_0001);
    chk("idcode_strobes", 64'({c_cap, c_shf0, c_upd}), 64'b111);

    // BYPASS via 5'h1F and via an unassigned opcode
    shift_ir(5'h1F, irc);
    chk("ir_capture", 64'(irc), 64'b00101);
    chk("bypass_irdec", 64'({dmi_access_o, dtmcs_select_o}), 64'd0);
    shift_dr(64'h1, 2, d);
    chk("bypass_a", 64'(d[1:0]), 64'b10);
    shift_dr(64'h2, 3, d);
    chk("bypass_b", 64'(d[2:0]), 64'b100);
    shift_ir(5'h05, irc);
    shift_dr(64'h1, 2, d);
    chk("bypass_unk", 64'(d[1:0]), 64'b10);

    // DTMCS read
    dmi_error_i = 2'h3;
    shift_ir(5'h10, irc);
    chk("dtmcs_sel", 64'({dtmcs_select_o, dmi_access_o}), 64'b10);
    shift_dr(64'd0, 32, d);
    chk("dtmcs_read", d, 64'h0000_1C71);
    chk("dtmcs_norst", 64'({c_rst_upd, c_rst_idle}), 64'd0);

    // dmireset write pulses once, one cycle after UpdateDr
    dmi_error_i = 2'h1;
    r0 = n_rst;
    shift_dr(64'h0001_0000, 32, d);
    chk("dtmcs_read2", d, 64'h0000_1471);
    chk("dmirst_timing", 64'({c_upd, c_rst_upd, c_rst_idle}), 64'b101);
    step(1'b0, 1'b0);
    chk("dmirst_drop", 64'(dmi_reset_o), 64'd0);
    chk("dmirst_count", 64'(n_rst - r0), 64'd1);

    // Writing zero produces no pulse
    r0 = n_rst;
    shift_dr(64'd0, 32, d);
    step(1'b0, 1'b0);
    chk("dmirst_zero", 64'(n_rst - r0), 64'd0);

    // Hard reset bit
`ifdef JTAG_TAP_HARDRESET_EN
    exp_hr = 1;
`else
    exp_hr = 0;
`endif
    r0 = n_rst;
    h0 = n_hrst;
    shift_dr(64'h0002_0000, 32, d);
    step(1'b0, 1'b0);
    chk("hardrst_count", 64'(n_hrst - h0), 64'(exp_hr));
    chk("hardrst_dmirst", 64'(n_rst - r0), 64'(exp_hr));
    shift_dr(64'd0, 32, d);
    chk("dtmcs_bit17_rd", d, 64'h0000_1471);

    // DMI access: strobes, serial path in both directions
    shift_ir(5'h11, irc);
    chk("dmi_sel", 64'({dmi_access_o, dtmcs_select_o}), 64'b10);
    a0 = n_cap;
    b0 = n_shf;
    u0 = n_upd;
    shift_dr(64'h155_5555_5555, 41, d);
    chk("dmi_tdo", 64'(d[40:0]), 64'(DMI_PAT));
    chk("dmi_tdi", 64'(dmi_sr), 64'h155_5555_5555 & 64'h1FF_FFFF_FFFF);
    chk("dmi_strobe_cyc", 64'({c_cap, c_shf0, c_upd}), 64'b111);
    chk("dmi_cap_cnt", 64'(n_cap - a0), 64'd1);
    chk("dmi_shf_cnt", 64'(n_shf - b0), 64'd41);
    chk("dmi_upd_cnt", 64'(n_upd - u0), 64'd1);

    // Five TMS=1 from PauseDr reach TestLogicReset and force IDCODE
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    repeat (5) step(1'b1, 1'b0);
    chk("tms_tlr", 64'(test_logic_reset_o), 64'd1);
    step(1'b0, 1'b0);
    chk("tms_ir_idcode", 64'({dmi_access_o, dtmcs_select_o}), 64'd0);

    // Asynchronous TRST in the middle of ShiftDr
    shift_ir(5'h11, irc);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("pre_trst_oe", 64'(tdo_oe_o), 64'd1);
    #2 trst_ni = 1'b0;
    #1;
    chk("trst_tlr", 64'(test_logic_reset_o), 64'd1);
    chk("trst_outs", 64'({tdo_oe_o, td_o, shift_dr_o, dmi_access_o}), 64'd0);
    trst_ni = 1'b1;
    @(negedge tck_i); #1;
    tlr_to_idle();
    shift_dr(64'd0, 32, d);
    chk("trst_idcode", d, 64'h0000_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
